udp_video_rx: RTL and testbench

//  GMII receive-side parser, the counterpart of the UDP video transmitter. It runs on
//  e_rxc, strips Ethernet/IPv4/UDP headers and checks them, extracts the 11-bit frame

---
 rtl/udp_video_rx.sv | 190 +++++++++++++++++++
 tb/tb_udp_video_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_video_rx.sv
// rtl/udp_video_rx.sv - GMII receive parser: strips Ethernet/IPv4/UDP headers and streams video payload bytes
module udp_video_rx #(
   parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_FE_C0,
   parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0002,
   parameter logic [15:0] LOCAL_PORT  = 16'd8080,
   parameter logic [15:0] MAX_PAYLOAD = 16'd864
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxdv,
   input  logic        rxer,
   input  logic [7:0]  rxd,
   input  logic        fifo_full,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sop,
   output logic        out_eop,
   output logic [10:0] frame_index,
   output logic        pkt_ok,
   output logic        pkt_err,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt
);
   typedef enum logic [3:0] {
      S_WAIT_IDLE, S_IDLE, S_PREAMBLE, S_ETH, S_IP, S_UDP, S_INDEX, S_PAYLOAD, S_DROP
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [10:0] r_cnt;
   logic        r_mac_loc, r_mac_bc, r_mac_pass;
   logic [15:0] r_len;
   logic [10:0] r_pay_len, r_shadow;
   logic [7:0]  w_mac_byte, w_ip_byte;
   logic        w_bad, w_hdr_err, w_drop, w_wr, w_sop, w_eop, w_ok, w_err, w_trunc;
   logic        w_mac_loc, w_mac_bc, w_mac_set;

   // a byte that arrives without rxdv or with rxer kills any frame in progress
   assign w_bad     = !rxdv || rxer;
   assign w_mac_loc = ((r_cnt == 11'd0) || r_mac_loc) && (rxd == w_mac_byte);
   assign w_mac_bc  = ((r_cnt == 11'd0) || r_mac_bc) && (rxd == 8'hFF);
   assign w_mac_set = (r_state == S_ETH) && (r_cnt == 11'd5) && !w_drop;
   // errors are only reported once the frame was known to be addressed to us
   assign w_err     = w_drop && r_mac_pass;
   assign w_trunc   = w_drop && (r_state == S_PAYLOAD) && (r_cnt != 11'd0);

   // expected MAC / IP byte for the current header offset
   always_comb begin
      w_mac_byte = LOCAL_MAC[7:0];
      w_ip_byte  = LOCAL_IP[7:0];
      case (r_cnt[2:0])
         3'd0:    w_mac_byte = LOCAL_MAC[47:40];
         3'd1:    w_mac_byte = LOCAL_MAC[39:32];
         3'd2:    w_mac_byte = LOCAL_MAC[31:24];
         3'd3:    w_mac_byte = LOCAL_MAC[23:16];
         3'd4:    w_mac_byte = LOCAL_MAC[15:8];
         default: w_mac_byte = LOCAL_MAC[7:0];
      endcase
      case (r_cnt[1:0])
         2'd0:    w_ip_byte = LOCAL_IP[31:24];
         2'd1:    w_ip_byte = LOCAL_IP[23:16];
         2'd2:    w_ip_byte = LOCAL_IP[15:8];
         default: w_ip_byte = LOCAL_IP[7:0];
      endcase
   end

   // header field checks at fixed byte offsets within each header state
   always_comb begin
      w_hdr_err = 1'b0;
      case (r_state)
         S_ETH: begin
            if (r_cnt == 11'd5 && !(w_mac_loc || w_mac_bc)) w_hdr_err = 1'b1;
            if (r_cnt == 11'd12 && rxd != 8'h08)            w_hdr_err = 1'b1;
            if (r_cnt == 11'd13 && rxd != 8'h00)            w_hdr_err = 1'b1;
         end
         S_IP: begin
            if (r_cnt == 11'd0 && rxd != 8'h45)             w_hdr_err = 1'b1;
            if (r_cnt == 11'd9 && rxd != 8'h11)             w_hdr_err = 1'b1;
            if (r_cnt >= 11'd16 && rxd != w_ip_byte)        w_hdr_err = 1'b1;
         end
         S_UDP: begin
            if (r_cnt == 11'd2 && rxd != LOCAL_PORT[15:8])  w_hdr_err = 1'b1;
            if (r_cnt == 11'd3 && rxd != LOCAL_PORT[7:0])   w_hdr_err = 1'b1;
            if (r_cnt == 11'd7 && (r_len < 16'd11 || r_len > MAX_PAYLOAD + 16'd8))
               w_hdr_err = 1'b1;
         end
         default: w_hdr_err = 1'b0;
      endcase
   end

   // next-state and per-byte decisions
   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_sop       = 1'b0;
      w_eop       = 1'b0;
      w_ok        = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         S_WAIT_IDLE: if (!rxdv) w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (rxdv) w_state_nxt = (!rxer && rxd == 8'h55) ? S_PREAMBLE : S_WAIT_IDLE;
         end
         S_PREAMBLE: begin
            if (w_bad)                                w_drop = 1'b1;
            else if (rxd == 8'hD5)                    w_state_nxt = S_ETH;
            else if (!(rxd == 8'h55 && r_cnt < 11'd6)) w_drop = 1'b1;
         end
         S_ETH: begin
            if (w_bad || w_hdr_err)       w_drop = 1'b1;
            else if (r_cnt == 11'd13)     w_state_nxt = S_IP;
         end
         S_IP: begin
            if (w_bad || w_hdr_err)       w_drop = 1'b1;
            else if (r_cnt == 11'd19)     w_state_nxt = S_UDP;
         end
         S_UDP: begin
            if (w_bad || w_hdr_err)       w_drop = 1'b1;
            else if (r_cnt == 11'd7)      w_state_nxt = S_INDEX;
         end
         S_INDEX: begin
            if (w_bad)                    w_drop = 1'b1;
            else if (r_cnt == 11'd1)      w_state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (w_bad || fifo_full) begin
               w_drop = 1'b1;
            end else begin
               w_wr  = 1'b1;
               w_sop = (r_cnt == 11'd0);
               if (r_cnt == r_pay_len - 11'd1) begin
                  w_eop       = 1'b1;
                  w_ok        = 1'b1;
                  w_state_nxt = S_WAIT_IDLE;
               end
            end
         end
         S_DROP:  w_state_nxt = S_WAIT_IDLE;
         default: w_state_nxt = S_WAIT_IDLE;
      endcase
      if (w_drop) w_state_nxt = S_DROP;
   end

   // state, byte counter, latched header fields and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_WAIT_IDLE;
         r_cnt       <= 11'd0;
         r_mac_loc   <= 1'b0;
         r_mac_bc    <= 1'b0;
         r_mac_pass  <= 1'b0;
         r_len       <= 16'd0;
         r_pay_len   <= 11'd0;
         r_shadow    <= 11'd0;
         out_data    <= 8'd0;
         out_valid   <= 1'b0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         frame_index <= 11'd0;
         pkt_ok      <= 1'b0;
         pkt_err     <= 1'b0;
         ok_cnt      <= 16'd0;
         err_cnt     <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= (w_state_nxt != r_state) ? 11'd0 : r_cnt + 11'd1;
         if (r_state == S_ETH) begin
            r_mac_loc <= w_mac_loc;
            r_mac_bc  <= w_mac_bc;
         end
         if (r_state == S_IDLE) r_mac_pass <= 1'b0;
         else if (w_mac_set)    r_mac_pass <= 1'b1;
         if (r_state == S_UDP && r_cnt == 11'd4) r_len[15:8] <= rxd;
         if (r_state == S_UDP && r_cnt == 11'd5) r_len[7:0]  <= rxd;
         if (r_state == S_UDP && r_cnt == 11'd7) r_pay_len   <= r_len[10:0] - 11'd10;
         if (r_state == S_INDEX && r_cnt == 11'd0) r_shadow[10:8] <= rxd[2:0];
         if (r_state == S_INDEX && r_cnt == 11'd1) r_shadow[7:0]  <= rxd;
         out_valid <= w_wr;
         if (w_wr) out_data <= rxd;
         out_sop <= w_sop;
         out_eop <= w_eop || w_trunc;
         pkt_ok  <= w_ok;
         pkt_err <= w_err;
         if (w_ok) begin
            frame_index <= r_shadow;
            ok_cnt      <= ok_cnt + 16'd1;
         end
         if (w_err) err_cnt <= err_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_udp_video_rx.sv
// tb/tb_udp_video_rx.sv - directed and randomized frames for udp_video_rx checked against a byte-image model
module tb_udp_video_rx;
   localparam logic [47:0] LMAC = 48'h000A3501FEC0;
   localparam logic [31:0] LIP  = 32'hC0A80002;

   logic        clk = 1'b0, rst = 1'b1, rxdv = 1'b0, rxer = 1'b0, fifo_full = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic [7:0]  out_data;
   logic        out_valid, out_sop, out_eop, pkt_ok, pkt_err;
   logic [10:0] frame_index;
   logic [15:0] ok_cnt, err_cnt;

   int          n_assert = 0, n_fail = 0;
   logic [7:0]  frame[$], exp_q[$], got[$];
   int          tot_sop = 0, tot_sop_bad = 0, sop_pos = 0, tot_eopv = 0, eop_pos = 0;
   int          tot_trunc = 0, tot_okp = 0, tot_errp = 0;
   int          b_got, b_sop, b_sop_bad, b_eopv, b_trunc, b_okp, b_errp;
   logic [15:0] m_ok = 16'd0, m_err = 16'd0;
   logic [10:0] m_idx = 11'd0;
   bit          e_ok, e_err, e_trunc;

   udp_video_rx dut (
      .clk(clk), .rst(rst), .rxdv(rxdv), .rxer(rxer), .rxd(rxd), .fifo_full(fifo_full),
      .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .frame_index(frame_index), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
      .ok_cnt(ok_cnt), .err_cnt(err_cnt)
   );

   always #4 clk = ~clk;

   // output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (out_sop) begin
         tot_sop++;
         sop_pos = got.size();
         if (!out_valid) tot_sop_bad++;
      end
      if (out_valid) got.push_back(out_data);
      if (out_eop && out_valid) begin
         tot_eopv++;
         eop_pos = got.size();
      end
      if (out_eop && !out_valid) tot_trunc++;
      if (pkt_ok)  tot_okp++;
      if (pkt_err) tot_errp++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push16(input logic [15:0] v);
      frame.push_back(v[15:8]);
      frame.push_back(v[7:0]);
   endtask

   task automatic build(input int npre, input logic [47:0] mac, input logic [15:0] port,
                        input logic [15:0] len, input logic [10:0] idx, input bit seq);
      int nd;
      nd = (len > 16'd10) ? int'(len) - 10 : 0;
      frame.delete();
      repeat (npre) frame.push_back(8'h55);
      frame.push_back(8'hD5);
      for (int i = 0; i < 6; i++) frame.push_back(8'(mac >> (40 - 8 * i)));
      for (int i = 0; i < 6; i++) frame.push_back(8'($urandom));
      push16(16'h0800);
      push16(16'h4500);
      push16(len + 16'd20);
      push16(16'($urandom));
      push16(16'h4000);
      push16(16'h4011);
      push16(16'h0000);
      push16(16'hC0A8); push16(16'h0001);
      push16(LIP[31:16]); push16(LIP[15:0]);
      push16(16'd8080);
      push16(port);
      push16(len);
      push16(16'h0000);
      push16({5'b00000, idx});
      for (int i = 0; i < nd; i++) frame.push_back(seq ? 8'(i) : 8'($urandom));
      repeat ($urandom_range(0, 3)) frame.push_back(8'h00);
      repeat (4) frame.push_back(8'($urandom));
   endtask

   // reference: reads the header fields at their fixed offsets in the byte image
   // and works out what reaches the FIFO and how the packet is reported
   task automatic predict(input int err_at, input int full_at, input int cut_at);
      int          g, p, h, u, s, k;
      logic [47:0] mac;
      logic [31:0] dip;
      logic [15:0] len;
      bit          mac_ok, hdr_ok;
      g = frame.size();
      if (cut_at >= 0 && cut_at < g) g = cut_at;
      if (err_at >= 0 && err_at < g) g = err_at;
      p = 0;
      while (p < frame.size() && frame[p] == 8'h55) p++;
      h = p + 1; u = h + 34; s = u + 10;
      mac = '0; dip = '0;
      for (int j = 0; j < 6; j++) mac = {mac[39:0], frame[h + j]};
      for (int j = 0; j < 4; j++) dip = {dip[23:0], frame[h + 30 + j]};
      len = {frame[u + 4], frame[u + 5]};
      mac_ok = p >= 1 && p <= 7 && p < g && frame[p] == 8'hD5 && g >= h + 6 &&
               (mac == LMAC || mac == 48'hFFFF_FFFF_FFFF);
      hdr_ok = {frame[h + 12], frame[h + 13]} == 16'h0800 && frame[h + 14] == 8'h45 &&
               frame[h + 23] == 8'h11 && dip == LIP && {frame[u + 2], frame[u + 3]} == 16'd8080 &&
               len >= 16'd11 && len <= 16'd872;
      k = 0;
      if (hdr_ok) begin
         k = int'(len) - 10;
         if (g - s < k) k = g - s;
         if (full_at >= 0 && full_at - s < k) k = full_at - s;
         if (k < 0) k = 0;
      end
      e_ok    = mac_ok && hdr_ok && (k == int'(len) - 10);
      e_err   = mac_ok && !e_ok;
      e_trunc = e_err && (k > 0);
      exp_q.delete();
      if (mac_ok) for (int i = 0; i < k; i++) exp_q.push_back(frame[s + i]);
      if (e_ok) begin
         m_ok++;
         m_idx = {frame[s - 2][2:0], frame[s - 1]};
      end
      if (e_err) m_err++;
   endtask

   task automatic clr_mon();
      b_got = got.size(); b_sop = tot_sop; b_sop_bad = tot_sop_bad; b_eopv = tot_eopv;
      b_trunc = tot_trunc; b_okp = tot_okp; b_errp = tot_errp;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".out_data"}, out_data, 0);
      chk({tag, ".out_sop"}, out_sop, 0);
      chk({tag, ".out_eop"}, out_eop, 0);
      chk({tag, ".pkt_ok"}, pkt_ok, 0);
      chk({tag, ".pkt_err"}, pkt_err, 0);
      chk({tag, ".frame_index"}, frame_index, 0);
      chk({tag, ".ok_cnt"}, ok_cnt, 0);
      chk({tag, ".err_cnt"}, err_cnt, 0);
   endtask

   task automatic send(input int err_at, input int full_at, input int cut_at, input int rst_at);
      int n;
      n = (cut_at >= 0 && cut_at < frame.size()) ? cut_at : frame.size();
      for (int i = 0; i < n; i++) begin
         rxdv = 1'b1; rxd = frame[i]; rxer = (i == err_at); rst = (i == rst_at);
         fifo_full = (full_at >= 0 && i >= full_at);
         @(posedge clk); #1;
         if (i == rst_at) begin
            rst = 1'b0;
            chk_reset("midrst");
            clr_mon();
         end
      end
      rxdv = 1'b0; rxd = 8'h00; rxer = (n == err_at); fifo_full = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      rxer = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
   endtask

   task automatic check_frame(input string tag);
      int nb, mism;
      nb = got.size() - b_got;
      mism = 0;
      for (int i = 0; i < nb && i < exp_q.size(); i++) if (got[b_got + i] !== exp_q[i]) mism++;
      chk({tag, ".nbytes"}, nb, exp_q.size());
      chk({tag, ".data_mism"}, mism, 0);
      chk({tag, ".sop_cnt"}, tot_sop - b_sop, (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) chk({tag, ".sop_pos"}, sop_pos - b_got, 0);
      chk({tag, ".sop_novalid"}, tot_sop_bad - b_sop_bad, 0);
      chk({tag, ".eop_cnt"}, tot_eopv - b_eopv, e_ok ? 1 : 0);
      if (e_ok) chk({tag, ".eop_pos"}, eop_pos - b_got, exp_q.size());
      chk({tag, ".trunc"}, tot_trunc - b_trunc, e_trunc ? 1 : 0);
      chk({tag, ".pkt_ok"}, tot_okp - b_okp, e_ok ? 1 : 0);
      chk({tag, ".pkt_err"}, tot_errp - b_errp, e_err ? 1 : 0);
      chk({tag, ".frame_index"}, frame_index, m_idx);
      chk({tag, ".ok_cnt"}, ok_cnt, m_ok);
      chk({tag, ".err_cnt"}, err_cnt, m_err);
   endtask

   task automatic run(input string tag, input int err_at, input int full_at, input int cut_at);
      clr_mon();
      predict(err_at, full_at, cut_at);
      send(err_at, full_at, cut_at, -1);
      check_frame(tag);
   endtask

   initial begin
      int          s, np, sel, fault, pos;
      logic [47:0] mac;
      logic [15:0] len, port;

      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // valid 872-byte UDP packet with counting data
      build(7, LMAC, 16'd8080, 16'd872, 11'h123, 1'b1);
      run("t1", -1, -1, -1);
      chk("t1.count", got.size() - b_got, 862);
      chk("t1.first", got[b_got], 8'h00);
      chk("t1.last", got[b_got + 861], 8'h5D);
      chk("t1.index", frame_index, 11'h123);
      chk("t1.ok_cnt", ok_cnt, 16'd1);

      // wrong destination port
      build(7, LMAC, 16'd8081, 16'd872, 11'h2AA, 1'b1);
      run("t2", -1, -1, -1);
      chk("t2.err_cnt", err_cnt, 16'd1);
      chk("t2.index", frame_index, 11'h123);

      // rxer on payload byte 100
      build(7, LMAC, 16'd8080, 16'd300, 11'h055, 1'b0);
      s = 7 + 45;
      run("t3", s + 100, -1, -1);
      chk("t3.count", got.size() - b_got, 100);
      chk("t3.trunc", tot_trunc - b_trunc, 1);

      // fifo full at payload byte 5, then a clean packet
      build(7, LMAC, 16'd8080, 16'd200, 11'h077, 1'b0);
      run("t4", -1, s + 5, -1);
      chk("t4.count", got.size() - b_got, 5);
      build(7, LMAC, 16'd8080, 16'd100, 11'h3C1, 1'b0);
      run("t4b", -1, -1, -1);

      // reset mid-payload with rxdv held, rest of the frame ignored
      build(7, LMAC, 16'd8080, 16'd150, 11'h111, 1'b0);
      send(-1, -1, -1, s + 20);
      exp_q.delete(); e_ok = 1'b0; e_err = 1'b0; e_trunc = 1'b0;
      m_ok = 16'd0; m_err = 16'd0; m_idx = 11'd0;
      check_frame("t5");
      build(3, LMAC, 16'd8080, 16'd40, 11'h222, 1'b0);
      run("t5b", -1, -1, -1);

      // broadcast with L=10, then a foreign MAC
      build(7, 48'hFFFF_FFFF_FFFF, 16'd8080, 16'd10, 11'h001, 1'b0);
      run("t6", -1, -1, -1);
      build(7, 48'h0200_0000_0001, 16'd8080, 16'd60, 11'h002, 1'b0);
      run("t6b", -1, -1, -1);

      // boundaries: one-byte payload, oversize, preamble lengths, rxer with rxdv falling
      build(1, LMAC, 16'd8080, 16'd11, 11'h7FF, 1'b0);
      run("l11", -1, -1, -1);
      build(7, LMAC, 16'd8080, 16'd873, 11'h004, 1'b0);
      run("l873", -1, -1, -1);
      build(8, LMAC, 16'd8080, 16'd30, 11'h005, 1'b0);
      run("pre8", -1, -1, -1);
      build(5, LMAC, 16'd8080, 16'd50, 11'h006, 1'b0);
      run("errcut", 5 + 45 + 10, -1, 5 + 45 + 10);

      // randomized frames
      for (int t = 0; t < 14; t++) begin
         np   = ($urandom_range(0, 7) == 0) ? 8 : int'($urandom_range(1, 7));
         sel  = int'($urandom_range(0, 4));
         mac  = (sel == 0) ? {16'h0200, 32'($urandom)} : (sel == 1) ? 48'hFFFF_FFFF_FFFF : LMAC;
         port = ($urandom_range(0, 5) == 0) ? 16'd8079 : 16'd8080;
         case ($urandom_range(0, 7))
            0:       len = 16'd10;
            1:       len = 16'd873;
            2:       len = 16'd11;
            default: len = 16'($urandom_range(12, 90));
         endcase
         build(np, mac, port, len, 11'($urandom), 1'b0);
         if ($urandom_range(0, 4) == 0) begin
            pos = int'($urandom_range(np + 1, np + 46));
            frame[pos] = frame[pos] ^ 8'($urandom_range(1, 255));
         end
         fault = int'($urandom_range(0, 3));
         pos   = int'($urandom_range(0, frame.size() - 1));
         run($sformatf("rnd%0d", t), (fault == 1) ? pos : -1, (fault == 2) ? pos : -1,
             (fault == 3) ? pos : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
